// File: rtl/debouncer_de_botoes_da_senha.sv
// Debounces the four password push-buttons and reports each accepted press as a
// one-cycle one-hot code. Optional press counter: define CONTADOR_DE_TECLAS_EN.
module debouncer_de_botoes_da_senha #(
  parameter int unsigned CICLOS_ESTAVEIS = 500000,
  parameter int unsigned LARGURA_CONT    = 20,
  parameter bit          ATIVO_BAIXO     = 1'b1
) (
  input  logic       CLK,
  input  logic       ON_OFF,
  input  logic [3:0] BOTOES,
  output logic [3:0] SENHA_INSERIDA,
  output logic       TECLA_INVALIDA,
  output logic       OCUPADO,
`ifdef CONTADOR_DE_TECLAS_EN
  output logic [3:0] TECLAS_ACEITAS,
`endif
  output logic [1:0] ESTADO_DBG
);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    CONFIRMANDO = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] CNT_MAX = LARGURA_CONT'(CICLOS_ESTAVEIS - 1);

  estado_t                 estado_q;
  logic [LARGURA_CONT-1:0] cnt_q;
  logic [3:0]              codigo_q;
  logic [3:0]              sync1_q;
  logic [3:0]              sync2_q;
  logic [3:0]              senha_q;
  logic                    invalida_q;
  logic [3:0]              botoes_norm;
`ifdef CONTADOR_DE_TECLAS_EN
  logic [3:0]              teclas_q;
`endif

  assign botoes_norm = ATIVO_BAIXO ? ~BOTOES : BOTOES;

  // Outputs are plain pulses with no handshake: SENHA_INSERIDA / TECLA_INVALIDA
  // are valid for exactly the one cycle they are nonzero; the consumer cannot stall them.
  always_ff @(posedge CLK) begin
    if (!ON_OFF) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      estado_q   <= OCIOSO;
      cnt_q      <= '0;
      codigo_q   <= '0;
      senha_q    <= '0;
      invalida_q <= 1'b0;
`ifdef CONTADOR_DE_TECLAS_EN
      teclas_q   <= '0;
`endif
    end else begin
      sync1_q    <= botoes_norm;
      sync2_q    <= sync1_q;
      senha_q    <= '0;
      invalida_q <= 1'b0;
      case (estado_q)
        OCIOSO: begin
          if (sync2_q != 4'b0000) begin
            codigo_q <= sync2_q;
            cnt_q    <= '0;
            estado_q <= CONFIRMANDO;
          end
        end
        CONFIRMANDO: begin
          if (sync2_q != codigo_q) begin
            estado_q <= OCIOSO;
          end else if (cnt_q == CNT_MAX) begin
            estado_q <= PRESSIONADO;
            if ($onehot(codigo_q)) begin
              senha_q <= codigo_q;
`ifdef CONTADOR_DE_TECLAS_EN
              teclas_q <= teclas_q + 4'd1;
`endif
            end else begin
              invalida_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSIONADO: begin
          // Changes while held are ignored; only a full release re-arms.
          if (sync2_q == 4'b0000) begin
            cnt_q    <= '0;
            estado_q <= SOLTANDO;
          end
        end
        SOLTANDO: begin
          if (sync2_q != 4'b0000) begin
            estado_q <= PRESSIONADO;
          end else if (cnt_q == CNT_MAX) begin
            estado_q <= OCIOSO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign SENHA_INSERIDA = senha_q;
  assign TECLA_INVALIDA = invalida_q;
  assign OCUPADO        = (estado_q != OCIOSO);
  assign ESTADO_DBG     = estado_q;
`ifdef CONTADOR_DE_TECLAS_EN
  assign TECLAS_ACEITAS = teclas_q;
`endif

endmodule

// File: tb/tb_debouncer_de_botoes_da_senha.sv
// Randomised and directed bench for the password-button debouncer, with a
// timestamp-based reference model feeding a pulse scoreboard.
module tb_debouncer_de_botoes_da_senha;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       on_off;
  logic [3:0] botoes;
  logic [3:0] senha;
  logic       inv;
  logic       ocupado;
  logic [1:0] estado_dbg;
`ifdef CONTADOR_DE_TECLAS_EN
  logic [3:0] teclas;
`endif

  always #5 clk = ~clk;

  debouncer_de_botoes_da_senha #(
    .CICLOS_ESTAVEIS(N),
    .LARGURA_CONT   (4),
    .ATIVO_BAIXO    (1'b1)
  ) dut (
    .CLK           (clk),
    .ON_OFF        (on_off),
    .BOTOES        (botoes),
    .SENHA_INSERIDA(senha),
    .TECLA_INVALIDA(inv),
    .OCUPADO       (ocupado),
`ifdef CONTADOR_DE_TECLAS_EN
    .TECLAS_ACEITAS(teclas),
`endif
    .ESTADO_DBG    (estado_dbg)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Expected pulse: {cycle stamp[31:0], code[3:0], invalid}
  logic [36:0] exp_q[$];

  // Reference model: samples reach the debouncer two edges late; a press is
  // accepted when the same code is still seen N edges after it was first seen
  // from idle, and the button is free again N edges after release was first seen.
  logic [3:0] hist[$];
  int         m_phase = 0;   // 0 free, 1 checking press, 2 held, 3 checking release
  int         m_since = 0;
  logic [3:0] m_code  = 4'h0;
  logic [3:0] m_s;
  logic       m_busy  = 1'b0;
  logic [3:0] m_cnt   = 4'h0;

  initial begin
    hist.push_back(4'h0);
    hist.push_back(4'h0);
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!on_off) begin
      hist.delete();
      hist.push_back(4'h0);
      hist.push_back(4'h0);
      m_phase = 0;
      m_cnt   = 4'h0;
    end else begin
      m_s = hist.pop_front();
      hist.push_back(~botoes);
      case (m_phase)
        0: if (m_s != 4'h0) begin m_code = m_s; m_since = cyc; m_phase = 1; end
        1: begin
          if (m_s != m_code) m_phase = 0;
          else if (cyc - m_since == N) begin
            m_phase = 2;
            if ($countones(m_code) == 1) begin
              exp_q.push_back({32'(cyc), m_code, 1'b0});
              m_cnt = m_cnt + 4'd1;
            end else begin
              exp_q.push_back({32'(cyc), 4'h0, 1'b1});
            end
          end
        end
        2: if (m_s == 4'h0) begin m_since = cyc; m_phase = 3; end
        default: begin
          if (m_s != 4'h0) m_phase = 2;
          else if (cyc - m_since == N) m_phase = 0;
        end
      endcase
    end
    m_busy = (m_phase != 0);
  end

  // Monitor / scoreboard
  logic [36:0] mon_e;
  int          n_valid = 0;
  int          n_inv   = 0;
  logic [3:0]  last_senha = 4'h0;

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][36:5]) < cyc) begin
        mon_e = exp_q.pop_front();
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL missed_pulse: got nothing, expected senha=%b inv=%b at cycle %0d",
                 mon_e[4:1], mon_e[0], int'(mon_e[36:5]));
      end
      if (senha !== 4'h0 || inv !== 1'b0) begin
        total = total + 1;
        if (senha !== 4'h0) begin n_valid = n_valid + 1; last_senha = senha; end
        if (inv === 1'b1) n_inv = n_inv + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_pulse: got senha=%b inv=%b at cycle %0d, expected no pulse",
                   senha, inv, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(mon_e[36:5]) != cyc || mon_e[4:1] !== senha || mon_e[0] !== inv) begin
            bad = bad + 1;
            $display("FAIL pulse: got senha=%b inv=%b at cycle %0d, expected senha=%b inv=%b at cycle %0d",
                     senha, inv, cyc, mon_e[4:1], mon_e[0], int'(mon_e[36:5]));
          end
        end
      end
      total = total + 1;
      if (ocupado !== m_busy) begin
        bad = bad + 1;
        $display("FAIL ocupado: got %b expected %b at cycle %0d", ocupado, m_busy, cyc);
      end
`ifdef CONTADOR_DE_TECLAS_EN
      total = total + 1;
      if (teclas !== m_cnt) begin
        bad = bad + 1;
        $display("FAIL teclas_aceitas: got %0d expected %0d at cycle %0d", teclas, m_cnt, cyc);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Driver: called on a negedge, sets the raw buttons and waits n cycles.
  task automatic drive(input logic [3:0] raw, input int n);
    botoes = raw;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse(input int n);
    on_off = 1'b0;
    repeat (n) @(negedge clk);
    on_off = 1'b1;
  endtask

  int v0;
  int i0;
  int r;
  logic [3:0] val;

  initial begin
    on_off = 1'b0;
    botoes = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_senha", 32'(senha), 32'h0);
    check("reset_invalida", 32'(inv), 32'h0);
    check("reset_ocupado", 32'(ocupado), 32'h0);
    mon_en = 1'b1;
    on_off = 1'b1;
    drive(4'hF, 5);

    // Clean press: pulse exactly after edge N+3, busy drops N+3 edges after release
    v0 = n_valid;
    botoes = 4'b1101;
    repeat (N + 2) @(negedge clk);
    check("clean_before_edge", 32'(senha), 32'h0);
    @(negedge clk);
    check("clean_pulse_edge", 32'(senha), 32'h2);
    @(negedge clk);
    check("clean_pulse_one_cycle", 32'(senha), 32'h0);
    repeat (20 - N - 4) @(negedge clk);
    botoes = 4'hF;
    repeat (N + 2) @(negedge clk);
    check("release_busy_held", 32'(ocupado), 32'h1);
    @(negedge clk);
    check("release_busy_fall", 32'(ocupado), 32'h0);
    drive(4'hF, 3);
    check("clean_count", 32'(n_valid - v0), 32'd1);
    check("clean_code", 32'(last_senha), 32'h2);

    // Bounce then stable hold
    v0 = n_valid;
    for (int k = 0; k < 3; k++) begin
      drive(4'b1110, 2);
      drive(4'b1111, 2);
    end
    check("bounce_no_pulse", 32'(n_valid - v0), 32'd0);
    drive(4'b1110, 15);
    drive(4'hF, 12);
    check("bounce_count", 32'(n_valid - v0), 32'd1);
    check("bounce_code", 32'(last_senha), 32'h1);

    // Multi-press
    v0 = n_valid; i0 = n_inv;
    drive(4'b0011, 10);
    drive(4'hF, 12);
    check("multi_invalid", 32'(n_inv - i0), 32'd1);
    check("multi_no_senha", 32'(n_valid - v0), 32'd0);

    // Hold with a short release glitch
    v0 = n_valid;
    drive(4'b0111, 15);
    drive(4'hF, 2);
    drive(4'b0111, 13);
    drive(4'hF, 12);
    check("glitch_count", 32'(n_valid - v0), 32'd1);
    check("glitch_code", 32'(last_senha), 32'h8);

    // Reset two samples into confirmation, button kept held
    v0 = n_valid;
    botoes = 4'b1011;
    repeat (4) @(negedge clk);
    on_off = 1'b0;
    @(negedge clk);
    check("rst_mid_senha", 32'(senha), 32'h0);
    check("rst_mid_ocupado", 32'(ocupado), 32'h0);
    on_off = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("rst_mid_no_early", 32'(n_valid - v0), 32'd0);
    @(negedge clk);
    check("rst_mid_pulse", 32'(senha), 32'h4);
    drive(4'b1011, 5);
    drive(4'hF, 12);
    check("rst_mid_count", 32'(n_valid - v0), 32'd1);

    // Randomised segments
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 11);
      if (r <= 5) begin
        val = 4'b0001 << $urandom_range(0, 3);
        drive(~val, $urandom_range(1, 12));
      end else if (r == 6) begin
        val = 4'($urandom_range(0, 15));
        drive(~val, $urandom_range(1, 12));
      end else if (r == 7) begin
        reset_pulse($urandom_range(1, 2));
      end else begin
        drive(4'hF, $urandom_range(1, 10));
      end
    end
    drive(4'hF, 20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
